// File: rtl/adder_tree_sequencer.sv
// Sequencer for the pipelined CSA adder tree: gates the tree enable, tracks in-flight
// samples, and sums WINDOW per-sample vs+vc results into one window total on a valid/ready port.
module adder_tree_sequencer #(
   parameter int MAX     = 36,
   parameter int LATENCY = 3,
   parameter int WINDOW  = 16,
   parameter int ACC_W   = MAX + $clog2(WINDOW) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             smp_valid,
   output logic             smp_ready,
   output logic             tree_en,
   input  logic [MAX-1:0]   vs,
   input  logic [MAX-1:0]   vc,
   output logic             pw_valid,
   input  logic             pw_ready,
   output logic [ACC_W-1:0] pw_data,
   output logic             busy,
   output logic             overrun_err,
   input  logic             clr_err
);

   localparam int CNT_W = $clog2(WINDOW);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [LATENCY-1:0] vld_sr;
   logic [LATENCY-1:0] vld_next;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   term;
   logic [ACC_W-1:0]   acc_sum;
   logic [CNT_W-1:0]   cnt;
   logic               active;
   logic               stall;
   logic               consume;
   logic               window_done;

   // Only the window-completing result can collide with an unaccepted total, so
   // the tree freezes just for that case and everything else keeps flowing.
   assign active      = (state == RUN) || (state == DRAIN);
   assign window_done = (cnt == CNT_LAST);
   assign stall       = pw_valid & ~pw_ready & window_done & vld_sr[LATENCY-1];
   assign tree_en     = active & ~stall;
   assign smp_ready   = (state == RUN) & tree_en;
   assign consume     = tree_en & vld_sr[LATENCY-1];
   assign busy        = (state != IDLE);

   assign term    = {{(ACC_W-MAX){vs[MAX-1]}}, vs} + {{(ACC_W-MAX){vc[MAX-1]}}, vc};
   assign acc_sum = acc + term;

   always_comb begin
      vld_next    = vld_sr;
      vld_next[0] = smp_valid & smp_ready;
      for (int i = 1; i < LATENCY; i++) begin
         vld_next[i] = vld_sr[i-1];
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (stop) state_next = DRAIN;
         DRAIN:   if (tree_en && (vld_sr == '0)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A completion in the same cycle as a transfer overrides the clear, so the
   // output stays valid with the fresh total and no bubble appears.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_sr   <= '0;
         acc      <= '0;
         cnt      <= '0;
         pw_data  <= '0;
         pw_valid <= 1'b0;
      end else begin
         if (tree_en) begin
            vld_sr <= vld_next;
         end
         if (pw_valid && pw_ready) begin
            pw_valid <= 1'b0;
         end
         if (consume) begin
            if (window_done) begin
               pw_data  <= acc_sum;
               pw_valid <= 1'b1;
               acc      <= '0;
               cnt      <= '0;
            end else begin
               acc <= acc_sum;
               cnt <= cnt + 1'b1;
            end
         end else if ((state == DRAIN) && (state_next == IDLE)) begin
            acc <= '0;
            cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         overrun_err <= 1'b0;
      end else if ((state == RUN) && smp_valid && !smp_ready) begin
         overrun_err <= 1'b1;
      end else if (clr_err) begin
         overrun_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adder_tree_sequencer.sv
// Bench for adder_tree_sequencer: a behavioural tree pipeline feeds vs/vc, and a
// scoreboard queue holds expected window totals that are popped on each output transfer.
module tb_adder_tree_sequencer;

   localparam int MAX   = 36;
   localparam int LAT   = 3;
   localparam int WIN   = 4;
   localparam int ACC_W = MAX + $clog2(WIN) + 1;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  start;
   logic                  stop;
   logic                  smp_valid;
   logic                  smp_ready;
   logic                  tree_en;
   logic [MAX-1:0]        vs;
   logic [MAX-1:0]        vc;
   logic                  pw_valid;
   logic                  pw_ready;
   logic [ACC_W-1:0]      pw_data;
   logic                  busy;
   logic                  overrun_err;
   logic                  clr_err;

   logic signed [MAX-1:0]   in_vs;
   logic signed [MAX-1:0]   in_vc;
   logic [MAX-1:0]          pipe_vs [LAT];
   logic [MAX-1:0]          pipe_vc [LAT];
   logic signed [ACC_W-1:0] part_sum;
   int                      part_cnt;
   logic [ACC_W-1:0]        exp_q [$];
   int                      errors = 0;
   int                      checks = 0;

   assign vs = pipe_vs[LAT-1];
   assign vc = pipe_vc[LAT-1];

   always #5 clk = ~clk;

   adder_tree_sequencer #(
      .MAX(MAX), .LATENCY(LAT), .WINDOW(WIN), .ACC_W(ACC_W)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .smp_valid(smp_valid), .smp_ready(smp_ready), .tree_en(tree_en),
      .vs(vs), .vc(vc), .pw_valid(pw_valid), .pw_ready(pw_ready),
      .pw_data(pw_data), .busy(busy), .overrun_err(overrun_err), .clr_err(clr_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Tree pipeline stand-in: bubbles carry random junk so consuming one would corrupt a total.
   task automatic tree_model();
      forever begin
         @(posedge clk);
         if (reset) begin
            part_sum = '0;
            part_cnt = 0;
            exp_q.delete();
            for (int i = 0; i < LAT; i++) begin
               pipe_vs[i] <= MAX'({$urandom(), $urandom()});
               pipe_vc[i] <= MAX'({$urandom(), $urandom()});
            end
         end else begin
            if (smp_valid && smp_ready) begin
               part_sum = part_sum + in_vs + in_vc;
               part_cnt++;
               if (part_cnt == WIN) begin
                  exp_q.push_back(part_sum);
                  part_sum = '0;
                  part_cnt = 0;
               end
            end
            if (tree_en) begin
               pipe_vs[0] <= (smp_valid && smp_ready) ? in_vs : MAX'({$urandom(), $urandom()});
               pipe_vc[0] <= (smp_valid && smp_ready) ? in_vc : MAX'({$urandom(), $urandom()});
               for (int i = 1; i < LAT; i++) begin
                  pipe_vs[i] <= pipe_vs[i-1];
                  pipe_vc[i] <= pipe_vc[i-1];
               end
            end
         end
      end
   endtask

   task automatic sb_monitor();
      logic [ACC_W-1:0] want;
      forever begin
         @(negedge clk);
         if (!reset && pw_valid && pw_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL sb_pop: pw_data=%0d but no total was expected", $signed(pw_data));
            end else begin
               want = exp_q.pop_front();
               if (pw_data !== want) begin
                  errors++;
                  $display("[TB] FAIL sb_data: pw_data=%0d expected %0d", $signed(pw_data), $signed(want));
               end
            end
         end
      end
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 40 && busy; i++) tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s_idle: busy=%b expected 0", name, busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      checks++;
      if ({pw_valid, pw_data, busy, tree_en, smp_ready, overrun_err} !== '0) begin
         errors++;
         $display("[TB] FAIL por_outputs: pw_valid=%b pw_data=%0d busy=%b tree_en=%b smp_ready=%b ovr=%b expected all 0",
                  pw_valid, pw_data, busy, tree_en, smp_ready, overrun_err);
      end
      pw_ready = 1'b0;
      in_vs = 36'sd1;
      in_vc = 36'sd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      smp_valid = 1'b1;
      for (int i = 0; i < 30 && !pw_valid; i++) tick();
      checks++;
      if (pw_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_setup: pw_valid=%b expected 1", pw_valid);
      end
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      smp_valid = 1'b0;
      checks++;
      if ({pw_valid, pw_data, busy, tree_en, smp_ready, overrun_err} !== '0) begin
         errors++;
         $display("[TB] FAIL midrun_reset: pw_valid=%b pw_data=%0d busy=%b tree_en=%b smp_ready=%b ovr=%b expected all 0",
                  pw_valid, pw_data, busy, tree_en, smp_ready, overrun_err);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_stays_idle: busy=%b expected 0", busy);
      end
   endtask

   task automatic test_basic();
      pw_ready = 1'b1;
      in_vs = 36'sd10;
      in_vc = 36'sd5;
      part_sum = '0;
      part_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 8; c++) begin
         smp_valid = (c <= 4);
         if (c == 7) begin
            checks++;
            if (pw_valid !== 1'b0) begin
               errors++;
               $display("[TB] FAIL basic_early: pw_valid=%b at cycle 7 expected 0", pw_valid);
            end
         end
         tick();
      end
      checks++;
      if (pw_valid !== 1'b1 || pw_data !== ACC_W'(60)) begin
         errors++;
         $display("[TB] FAIL basic_total: pw_valid=%b pw_data=%0d at cycle 8 expected 1/60", pw_valid, $signed(pw_data));
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_idle("basic");
   endtask

   task automatic test_signed();
      logic [ACC_W-1:0] want;
      want = ACC_W'(-16);
      pw_ready = 1'b1;
      in_vs = -36'sd7;
      in_vc = 36'sd3;
      part_sum = '0;
      part_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 8; c++) begin
         smp_valid = (c <= 4);
         tick();
      end
      checks++;
      if (pw_valid !== 1'b1 || pw_data !== want) begin
         errors++;
         $display("[TB] FAIL signed_total: pw_valid=%b pw_data=%0d expected 1/-16", pw_valid, $signed(pw_data));
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_idle("signed");
   endtask

   task automatic test_backpressure();
      int k;
      k = 0;
      pw_ready = 1'b0;
      part_sum = '0;
      part_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      smp_valid = 1'b1;
      for (int i = 0; i < 30 && tree_en; i++) begin
         in_vs = MAX'(3 * k);
         in_vc = MAX'(-k);
         k++;
         tick();
      end
      tick();
      tick();
      checks++;
      if (tree_en !== 1'b0 || smp_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_stall: tree_en=%b smp_ready=%b expected 0/0", tree_en, smp_ready);
      end
      checks++;
      if (overrun_err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_overrun: overrun_err=%b expected 1", overrun_err);
      end
      checks++;
      if (pw_valid !== 1'b1 || pw_data !== ACC_W'(12)) begin
         errors++;
         $display("[TB] FAIL bp_hold: pw_valid=%b pw_data=%0d expected 1/12", pw_valid, $signed(pw_data));
      end
      smp_valid = 1'b0;
      pw_ready = 1'b1;
      #1;
      checks++;
      if (tree_en !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_release_en: tree_en=%b expected 1 on coinciding transfer", tree_en);
      end
      tick();
      checks++;
      if (pw_valid !== 1'b1 || pw_data !== ACC_W'(44)) begin
         errors++;
         $display("[TB] FAIL bp_second: pw_valid=%b pw_data=%0d expected 1/44", pw_valid, $signed(pw_data));
      end
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      checks++;
      if (overrun_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_clr_err: overrun_err=%b expected 0", overrun_err);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_idle("bp");
   endtask

   task automatic test_stop_mid();
      pw_ready = 1'b1;
      in_vs = 36'sd50;
      in_vc = 36'sd50;
      part_sum = '0;
      part_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      smp_valid = 1'b1;
      tick();
      tick();
      stop = 1'b1;
      smp_valid = 1'b0;
      tick();
      stop = 1'b0;
      smp_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (busy !== 1'b1 || tree_en !== 1'b1 || smp_ready !== 1'b0 || pw_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_cycle%0d: busy=%b tree_en=%b smp_ready=%b pw_valid=%b expected 1/1/0/0",
                     c, busy, tree_en, smp_ready, pw_valid);
         end
         tick();
      end
      smp_valid = 1'b0;
      checks++;
      if (busy !== 1'b0 || pw_valid !== 1'b0 || overrun_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL drain_end: busy=%b pw_valid=%b ovr=%b expected 0/0/0", busy, pw_valid, overrun_err);
      end
      in_vs = 36'sd100;
      in_vc = -36'sd1;
      part_sum = '0;
      part_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 8; c++) begin
         smp_valid = (c <= 4);
         tick();
      end
      checks++;
      if (pw_valid !== 1'b1 || pw_data !== ACC_W'(396)) begin
         errors++;
         $display("[TB] FAIL restart_total: pw_valid=%b pw_data=%0d expected 1/396", pw_valid, $signed(pw_data));
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_idle("restart");
   endtask

   task automatic test_simultaneous();
      smp_valid = 1'b0;
      start = 1'b1;
      stop = 1'b1;
      tick();
      start = 1'b0;
      stop = 1'b0;
      checks++;
      if (busy !== 1'b1 || smp_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL idle_start_stop: busy=%b smp_ready=%b expected 1/1", busy, smp_ready);
      end
      start = 1'b1;
      stop = 1'b1;
      tick();
      start = 1'b0;
      stop = 1'b0;
      checks++;
      if (busy !== 1'b1 || smp_ready !== 1'b0 || tree_en !== 1'b1) begin
         errors++;
         $display("[TB] FAIL run_start_stop: busy=%b smp_ready=%b tree_en=%b expected 1/0/1", busy, smp_ready, tree_en);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL empty_drain: busy=%b expected 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      int r;
      part_sum = '0;
      part_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 80; c++) begin
         r = int'($urandom_range(0, 2000)) - 1000;
         in_vs = MAX'(r);
         r = int'($urandom_range(0, 2000)) - 1000;
         in_vc = MAX'(r);
         smp_valid = ($urandom_range(0, 3) != 0);
         pw_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      smp_valid = 1'b0;
      pw_ready = 1'b1;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_idle("b2b");
      for (int i = 0; i < 10 && pw_valid; i++) tick();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      checks++;
      if (exp_q.size() != 0 || pw_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_leftover: %0d totals undelivered, pw_valid=%b expected 0/0", exp_q.size(), pw_valid);
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      stop = 1'b0;
      smp_valid = 1'b0;
      pw_ready = 1'b0;
      clr_err = 1'b0;
      in_vs = '0;
      in_vc = '0;
      part_sum = '0;
      part_cnt = 0;
      fork
         tree_model();
         sb_monitor();
         begin
            #500000;
            $display("[TB] FAIL watchdog: simulation time limit reached");
            $fatal(1, "[TB] watchdog expired");
         end
      join_none
      $display("[TB] starting adder_tree_sequencer bench");
      test_reset();
      test_basic();
      test_signed();
      test_backpressure();
      test_stop_mid();
      test_simultaneous();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
